// File: rtl/fxp8s_pkg.sv
// Shared definitions for the fxp8s streamer: Q4.3 element format, matrix limits,
// streamer state encoding and the 2-bit dimension/index type.
package fxp8s_pkg;

    localparam int FXP8S_WIDTH   = 8;
    localparam int FXP8S_SIGN    = 7;
    localparam int FXP8S_LSB_POW = -3;
    localparam int MAX_DIM       = 3;

    typedef logic [1:0] fxp8s_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2,
        DONE   = 2'd3
    } fxp8s_state_t;

endpackage

// File: rtl/fxp8s_stream_ctr.sv
// Row/column position counter shared by both matrices; limits are switched by
// the owner, and the counter wraps to (0,0) after the last element of a matrix.
module fxp8s_stream_ctr
    import fxp8s_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_clr,
    input  logic       i_adv,
    input  fxp8s_idx_t i_rows,
    input  fxp8s_idx_t i_cols,
    output logic       o_mat_end,
    output fxp8s_idx_t o_nxt_row,
    output fxp8s_idx_t o_nxt_col
);

    fxp8s_idx_t r_row;
    fxp8s_idx_t r_col;
    logic       w_row_end;
    logic       w_mat_end;

    assign w_row_end = (r_col == i_cols - 2'd1);
    assign w_mat_end = w_row_end && (r_row == i_rows - 2'd1);
    assign o_mat_end = w_mat_end;

    always_comb begin
        o_nxt_row = r_row;
        o_nxt_col = r_col + 2'd1;
        if (w_mat_end) begin
            o_nxt_row = 2'd0;
            o_nxt_col = 2'd0;
        end else if (w_row_end) begin
            o_nxt_row = r_row + 2'd1;
            o_nxt_col = 2'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_clr) begin
            r_row <= 2'd0;
            r_col <= 2'd0;
        end else if (i_adv) begin
            r_row <= o_nxt_row;
            r_col <= o_nxt_col;
        end
    end

endmodule

// File: rtl/fxp8s_mat_streamer.sv
// Streams a buffered A matrix then B matrix (each up to 3x3 Q4.3) on an en/rdy
// stream with row-end and matrix-end markers. FXP8S_STREAM_CLR_EN clears the buffer on DONE.
module fxp8s_mat_streamer
    import fxp8s_pkg::*;
#(
    parameter int DATA_W = FXP8S_WIDTH
)
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr_en,
    input  logic              i_wr_mat,
    input  logic [1:0]        i_wr_row,
    input  logic [1:0]        i_wr_col,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_start,
    input  logic [1:0]        i_rows_a,
    input  logic [1:0]        i_cols_a,
    input  logic [1:0]        i_rows_b,
    input  logic [1:0]        i_cols_b,
    output logic              o_busy,
    output logic              o_cfg_err,
    output logic              o_out_en_data,
    input  logic              i_out_rdy_data,
    output logic              o_out_mat,
    output logic              o_out_new_row,
    output logic              o_out_mat_done,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a beat transfers on a rising edge where o_out_en_data and
    // i_out_rdy_data are both high; until then the beat and its markers hold.

    fxp8s_state_t      r_state, w_state_nxt;
    logic [DATA_W-1:0] r_a [0:MAX_DIM-1][0:MAX_DIM-1];
    logic [DATA_W-1:0] r_b [0:MAX_DIM-1][0:MAX_DIM-1];
    fxp8s_idx_t        r_rows_a, r_cols_a, r_rows_b, r_cols_b;
    logic              r_busy, r_cfg_err, r_en, r_mat, r_new_row, r_mat_done;
    logic [DATA_W-1:0] r_data;

    logic              w_dims_ok, w_start_ok, w_start_bad, w_xfer, w_mat_end;
    fxp8s_idx_t        w_lim_rows, w_lim_cols, w_nxt_row, w_nxt_col;
    logic              w_ld, w_ld_mat;
    fxp8s_idx_t        w_ld_row, w_ld_col, w_ld_rows, w_ld_cols;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_wr_ok, w_wr_hit;

    assign w_dims_ok   = (i_rows_a != 2'd0) && (i_cols_a != 2'd0) &&
                         (i_rows_b != 2'd0) && (i_cols_b != 2'd0) &&
                         (i_cols_a == i_rows_b);
    assign w_start_ok  = (r_state == IDLE) && i_start && w_dims_ok;
    assign w_start_bad = (r_state == IDLE) && i_start && !w_dims_ok;
    assign w_xfer      = r_en && i_out_rdy_data;
    assign w_lim_rows  = (r_state == SEND_B) ? r_rows_b : r_rows_a;
    assign w_lim_cols  = (r_state == SEND_B) ? r_cols_b : r_cols_a;
    assign w_wr_ok     = (r_state == IDLE) && i_wr_en &&
                         (i_wr_row != 2'd3) && (i_wr_col != 2'd3);

    fxp8s_stream_ctr u_ctr (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (w_start_ok),
        .i_adv     (w_xfer),
        .i_rows    (w_lim_rows),
        .i_cols    (w_lim_cols),
        .o_mat_end (w_mat_end),
        .o_nxt_row (w_nxt_row),
        .o_nxt_col (w_nxt_col)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = SEND_A;
            SEND_A:  if (w_xfer && w_mat_end) w_state_nxt = SEND_B;
            SEND_B:  if (w_xfer && w_mat_end) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Select the beat to present next: first A element, first B element, or the successor.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_mat  = (r_state == SEND_A);
        w_ld_row  = w_nxt_row;
        w_ld_col  = w_nxt_col;
        w_ld_rows = w_lim_rows;
        w_ld_cols = w_lim_cols;
        if (w_start_ok) begin
            w_ld      = 1'b1;
            w_ld_mat  = 1'b1;
            w_ld_row  = 2'd0;
            w_ld_col  = 2'd0;
            w_ld_rows = i_rows_a;
            w_ld_cols = i_cols_a;
        end else if (w_xfer && (r_state == SEND_A) && w_mat_end) begin
            w_ld      = 1'b1;
            w_ld_mat  = 1'b0;
            w_ld_row  = 2'd0;
            w_ld_col  = 2'd0;
            w_ld_rows = r_rows_b;
            w_ld_cols = r_cols_b;
        end else if (w_xfer && !((r_state == SEND_B) && w_mat_end)) begin
            w_ld = 1'b1;
        end
    end

    // A write landing in the same cycle as start must be visible in the first beat.
    assign w_wr_hit  = w_wr_ok && (i_wr_mat == w_ld_mat) &&
                       (i_wr_row == w_ld_row) && (i_wr_col == w_ld_col);
    assign w_ld_data = w_wr_hit ? i_wr_data :
                       (w_ld_mat ? r_a[w_ld_row][w_ld_col] : r_b[w_ld_row][w_ld_col]);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_busy     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_en       <= 1'b0;
            r_mat      <= 1'b0;
            r_new_row  <= 1'b0;
            r_mat_done <= 1'b0;
            r_data     <= '0;
            r_rows_a   <= 2'd0;
            r_cols_a   <= 2'd0;
            r_rows_b   <= 2'd0;
            r_cols_b   <= 2'd0;
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    r_a[r][c] <= '0;
                    r_b[r][c] <= '0;
                end
            end
        end else begin
            r_cfg_err <= w_start_bad;
            r_busy    <= (w_state_nxt != IDLE);
            if (w_start_ok) begin
                r_rows_a <= i_rows_a;
                r_cols_a <= i_cols_a;
                r_rows_b <= i_rows_b;
                r_cols_b <= i_cols_b;
            end
            if (w_ld) begin
                r_en       <= 1'b1;
                r_mat      <= w_ld_mat;
                r_data     <= w_ld_data;
                r_new_row  <= (w_ld_col == w_ld_cols - 2'd1);
                r_mat_done <= (w_ld_col == w_ld_cols - 2'd1) && (w_ld_row == w_ld_rows - 2'd1);
            end else if (w_xfer) begin
                r_en       <= 1'b0;
                r_mat      <= 1'b0;
                r_new_row  <= 1'b0;
                r_mat_done <= 1'b0;
                r_data     <= '0;
            end
            if (w_wr_ok) begin
                if (i_wr_mat) r_a[i_wr_row][i_wr_col] <= i_wr_data;
                else          r_b[i_wr_row][i_wr_col] <= i_wr_data;
            end
`ifdef FXP8S_STREAM_CLR_EN
            if (r_state == DONE) begin
                for (int r = 0; r < MAX_DIM; r++) begin
                    for (int c = 0; c < MAX_DIM; c++) begin
                        r_a[r][c] <= '0;
                        r_b[r][c] <= '0;
                    end
                end
            end
`else
`endif
        end
    end

    assign o_busy         = r_busy;
    assign o_cfg_err      = r_cfg_err;
    assign o_out_en_data  = r_en;
    assign o_out_mat      = r_mat;
    assign o_out_new_row  = r_new_row;
    assign o_out_mat_done = r_mat_done;
    assign o_out_data     = r_data;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fxp8s_mat_streamer.sv
// Directed bench for fxp8s_mat_streamer: expected beats are queued from a local
// buffer model at start and compared whenever the stream presents a beat.
module tb_fxp8s_mat_streamer;
    import fxp8s_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wr_en = 1'b0, wr_mat = 1'b0;
    logic [1:0] wr_row = 2'd0, wr_col = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic [1:0] rows_a = 2'd0, cols_a = 2'd0, rows_b = 2'd0, cols_b = 2'd0;
    logic       rdy = 1'b0;
    logic       busy, cfg_err, en, mat, new_row, mat_done;
    logic [7:0] data;
    logic [1:0] dbg_state;

    int         checks = 0;
    int         failures = 0;
    logic [10:0] exp_q[$];
    logic [7:0] ma [3][3];
    logic [7:0] mb [3][3];
    int         cyc;

    fxp8s_mat_streamer dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_wr_en(wr_en), .i_wr_mat(wr_mat), .i_wr_row(wr_row), .i_wr_col(wr_col),
        .i_wr_data(wr_data), .i_start(start),
        .i_rows_a(rows_a), .i_cols_a(cols_a), .i_rows_b(rows_b), .i_cols_b(cols_b),
        .o_busy(busy), .o_cfg_err(cfg_err), .o_out_en_data(en),
        .i_out_rdy_data(rdy), .o_out_mat(mat), .o_out_new_row(new_row),
        .o_out_mat_done(mat_done), .o_out_data(data), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat();
        return {21'd0, mat, new_row, mat_done, data};
    endfunction

    task automatic zero_model();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ma[r][c] = 8'd0;
                mb[r][c] = 8'd0;
            end
    endtask

    task automatic write_elem(input logic m, input int r, input int c, input logic [7:0] d);
        wr_en = 1'b1; wr_mat = m; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (m) ma[r][c] = d; else mb[r][c] = d;
    endtask

    task automatic load_all(input int mode);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                write_elem(1'b1, r, c, (mode == 0) ? 8'(r*3 + c + 1)  : 8'($urandom_range(0, 255)));
                write_elem(1'b0, r, c, (mode == 0) ? 8'(r*3 + c + 10) : 8'($urandom_range(0, 255)));
            end
    endtask

    task automatic push_stream(input int ra, input int ca, input int rb, input int cb);
        for (int r = 0; r < ra; r++)
            for (int c = 0; c < ca; c++)
                exp_q.push_back({1'b1, 1'(c == ca-1), 1'((c == ca-1) && (r == ra-1)), ma[r][c]});
        for (int r = 0; r < rb; r++)
            for (int c = 0; c < cb; c++)
                exp_q.push_back({1'b0, 1'(c == cb-1), 1'((c == cb-1) && (r == rb-1)), mb[r][c]});
    endtask

    task automatic start_ok(input int ra, input int ca, input int rb, input int cb,
                            input logic wr_a00, input logic [7:0] wd);
        rows_a = 2'(ra); cols_a = 2'(ca); rows_b = 2'(rb); cols_b = 2'(cb);
        start = 1'b1;
        if (wr_a00) begin
            wr_en = 1'b1; wr_mat = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = wd;
            ma[0][0] = wd;
        end
        push_stream(ra, ca, rb, cb);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("start_busy", busy, 1);
    endtask

    task automatic start_bad(input int ra, input int ca, input int rb, input int cb);
        rows_a = 2'(ra); cols_a = 2'(ca); rows_b = 2'(rb); cols_b = 2'(cb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", {busy, cfg_err, en}, 3'b010);
        @(negedge clk);
        check("cfg_err_clear", {busy, cfg_err, en}, 3'b000);
        check("cfg_state", dbg_state, IDLE);
    endtask

    task automatic stream(input int mode, input int nbeats, output int ncyc);
        int   xfers;
        logic r;
        xfers = 0;
        ncyc = 0;
        while (exp_q.size() != 0 && xfers != nbeats && ncyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (ncyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rdy = r;
            if (en) begin
                check("beat", beat(), {21'd0, exp_q[0]});
                if (r) begin
                    void'(exp_q.pop_front());
                    xfers++;
                end
            end
            @(negedge clk);
            ncyc++;
        end
        rdy = 1'b0;
        if (exp_q.size() != 0 && xfers != nbeats)
            check("stream_timeout", exp_q.size(), 0);
    endtask

    task automatic finish_check();
        check("done_en_low", en, 0);
        check("done_busy", busy, 1);
        check("done_state", dbg_state, DONE);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_state", dbg_state, IDLE);
`ifdef FXP8S_STREAM_CLR_EN
        zero_model();
`endif
    endtask

    initial begin
        zero_model();
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, cfg_err, en, mat, new_row, mat_done}, 6'd0);
        check("rst_data", data, 0);
        check("rst_state", dbg_state, IDLE);
        rstn = 1'b1;
        @(negedge clk);

        // Full 3x3 by 3x3 with ready held high: 18 back-to-back beats.
        load_all(0);
        start_ok(3, 3, 3, 3, 1'b0, 8'd0);
        stream(0, -1, cyc);
        check("full_cycles", cyc, 18);
        finish_check();

        // Second start without reload: retained values or zeros.
        start_ok(3, 3, 3, 3, 1'b0, 8'd0);
        stream(0, -1, cyc);
        finish_check();

        // 2x3 by 3x1 with a write to A[0][0] in the start cycle.
        load_all(0);
        start_ok(2, 3, 3, 1, 1'b1, 8'h55);
        stream(0, -1, cyc);
        check("small_cycles", cyc, 9);
        finish_check();

        // Ready toggling 1,0,0 with writes attempted mid-stream (must be ignored).
        start_ok(3, 3, 3, 3, 1'b0, 8'd0);
        wr_en = 1'b1; wr_mat = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h77;
        stream(1, -1, cyc);
        wr_en = 1'b0;
        finish_check();

        // 1x1 by 1x1 boundary, and a start attempt while busy.
        start_ok(1, 1, 1, 1, 1'b0, 8'd0);
        rows_a = 2'd3; cols_a = 2'd2; start = 1'b1;
        stream(0, -1, cyc);
        start = 1'b0;
        check("busy_start_no_err", cfg_err, 0);
        finish_check();

        // Rejected configurations.
        start_bad(3, 2, 3, 3);
        start_bad(0, 1, 1, 1);
        start_bad(1, 1, 1, 0);

        // Random signed data, non-square shapes, random ready.
        load_all(1);
        start_ok(3, 2, 2, 3, 1'b0, 8'd0);
        stream(2, -1, cyc);
        finish_check();
        load_all(1);
        start_ok(2, 1, 1, 3, 1'b0, 8'd0);
        stream(2, -1, cyc);
        finish_check();

        // Reset after the 4th beat abandons the stream and clears the buffer.
        load_all(0);
        start_ok(3, 3, 3, 3, 1'b0, 8'd0);
        stream(0, 4, cyc);
        rstn = 1'b0;
        exp_q.delete();
        zero_model();
        @(negedge clk);
        check("midrst_outputs", {busy, cfg_err, en, mat, new_row, mat_done}, 6'd0);
        check("midrst_state", dbg_state, IDLE);
        rstn = 1'b1;
        @(negedge clk);
        start_ok(3, 3, 3, 3, 1'b0, 8'd0);
        stream(0, -1, cyc);
        finish_check();
        load_all(0);
        start_ok(2, 2, 2, 2, 1'b0, 8'd0);
        stream(1, -1, cyc);
        finish_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
